mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory access sequencer between the processor datapath (MAR/MDR and control unit) and the external data memory. It accepts a single read or write request, drives address, write data and strobes toward memory, inserts wait states, and on reads delivers the memory word to the MDR with a one-cycle load pulse. It is the MDR's direct upstream stage: `mdrData`/`mdrLoad` feed the MDR's read input and load strobe, and `wrData` is taken from the MDR's write-data output.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `WAIT_CYCLES`, 2, minimum strobe-active cycles before `memReady` is honoured (0..15)
- `TIMEOUT_CYCLES`, 16, ACCESS-state cycle limit (used only with the timeout macro)

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `rdReq`  in  1  read request (level), sampled only in IDLE
- `wrReq`  in  1  write request (level), sampled only in IDLE
- `addrIn`  in  ADDR_W  address from MAR, latched on acceptance
- `wrData`  in  DATA_W  write data from MDR, latched on acceptance
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at transaction end
- `err`  out  1  sticky timeout flag
- `mdrData`  out  DATA_W  registered read data toward MDR
- `mdrLoad`  out  1  one-cycle load strobe toward MDR
- `memAddr`  out  ADDR_W  memory address (registered)
- `memWData`  out  DATA_W  memory write data (registered)
- `memRe`  out  1  memory read strobe
- `memWe`  out  1  memory write strobe
- `memRData`  in  DATA_W  memory read data
- `memReady`  in  1  memory ready/acknowledge

## Operation
- States: IDLE, SETUP, ACCESS, LOAD, DONE.
- IDLE: if `rdReq` → latch `addrIn`, set op=read, → SETUP. Else if `wrReq` → latch `addrIn`, `wrData`, op=write, → SETUP. Both high: read wins, write is not latched.
- SETUP (1 cycle): `memAddr`/`memWData` stable, strobes low. → ACCESS, wait counter cleared to 0.
- ACCESS: `memRe` (read) or `memWe` (write) high. Counter increments, saturating at WAIT_CYCLES. Exit when counter == WAIT_CYCLES and `memReady`=1: read → capture `memRData` into `mdrData`, → LOAD; write → DONE. Otherwise stay.
- LOAD (read only, 1 cycle): `mdrLoad`=1; `mdrData` already stable since the previous edge.
- DONE (1 cycle): strobes low, `done`=1. → IDLE unconditionally; a still-held request is accepted in the following IDLE cycle.
- Requests arriving while `busy` are ignored, not queued.
- `mdrData` holds its value between reads; writes never change it.
- Reset (low at an edge), in any state including mid-ACCESS: → IDLE; `busy`, `done`, `err`, `mdrLoad`, `memRe`, `memWe` = 0; `mdrData`, `memAddr`, `memWData` = 0. The aborted transaction produces no `done`.

## Timing
- Request sampled at edge N (IDLE). SETUP during cycle N+1, ACCESS from cycle N+2.
- With `memReady` already high: ACCESS lasts WAIT_CYCLES+1 cycles.
- Read: `mdrLoad` high in cycle N+WAIT_CYCLES+3, `done` in cycle N+WAIT_CYCLES+4.
- Write: `done` in cycle N+WAIT_CYCLES+3.
- Each cycle `memReady` stays low after the counter saturates adds one cycle.
- Minimum spacing between accepted requests: one IDLE cycle after DONE.

## Configuration
- `MEM_CTRL_TIMEOUT_EN` defined: an ACCESS cycle counter aborts after TIMEOUT_CYCLES cycles without completion. On abort: strobes drop, `err` is set, → DONE (`done` pulses, no `mdrLoad`, `mdrData` unchanged). `err` clears on reset or on the next accepted request.
- Not defined: ACCESS waits indefinitely for `memReady`; `err` is tied to 0.

## Structure
- Package `mem_ctrl_pkg`: state encoding constants (IDLE=0, SETUP=1, ACCESS=2, LOAD=3, DONE=4), op encoding (READ=0, WRITE=1), default widths.
- One sub-module `mem_wait_cnt`: saturating wait counter with clear, increment and `reached` output. Reused for the timeout counter when the macro is enabled.

## Test plan
- Read, WAIT_CYCLES=2, `memReady`=1, addr 0x0040, `memRData`=0xBEEF → `memRe` high for 3 cycles; `mdrLoad` at N+5 with `mdrData`=0xBEEF; `done` at N+6.
- Write addr 0x0100, data 0x1234, `memReady`=1 → `memWe` high 3 cycles with `memAddr`=0x0100 and `memWData`=0x1234; `done` at N+5; `mdrData` unchanged.
- `memReady` held low for 4 extra cycles → ACCESS extended by exactly 4 cycles; `done` shifted by 4.
- `rdReq` and `wrReq` high together → read only, `memWe` never asserted; `wrReq` pulse during `busy` → ignored.
- Reset low mid-ACCESS → next cycle all outputs 0, no `done`; new read after release completes normally.
- Macro on, TIMEOUT_CYCLES=16, `memReady` stuck low → abort after 16 ACCESS cycles: `err`=1, `done` pulse, no `mdrLoad`; next accepted request clears `err`.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings, default widths and sizing helper for the
// memory access sequencer.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF         = 16;
  localparam int unsigned DATA_W_DEF         = 16;
  localparam int unsigned WAIT_CYCLES_DEF    = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    LOAD   = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_e;

  // Bits needed to hold a count from 0 up to and including limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: processor-side request bus and memory-side strobes of the
// access sequencer. master = sequencer view, slave = datapath/memory view.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              rdReq;
  logic              wrReq;
  logic [ADDR_W-1:0] addrIn;
  logic [DATA_W-1:0] wrData;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] mdrData;
  logic              mdrLoad;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic              memRe;
  logic              memWe;
  logic [DATA_W-1:0] memRData;
  logic              memReady;

  modport master (
    input  rdReq, wrReq, addrIn, wrData, memRData, memReady,
    output busy, done, err, mdrData, mdrLoad, memAddr, memWData, memRe, memWe
  );

  modport slave (
    output rdReq, wrReq, addrIn, wrData, memRData, memReady,
    input  busy, done, err, mdrData, mdrLoad, memAddr, memWData, memRe, memWe
  );

endinterface

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: saturating up-counter with synchronous clear; reached is a
// registered flag equal to (count == LIMIT).
module mem_wait_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic reached
);

  localparam int unsigned W = cnt_width(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, increment stops at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count and reached flag registered together so they always agree.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      reached <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      reached <= (cnt_d == W'(LIMIT));
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-request memory access sequencer between MAR/MDR and data
// memory. Optional ACCESS timeout enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned WAIT_CYCLES    = WAIT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic        clk,
  input logic        reset,
  mem_ctrl_if.master bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_q, load_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              wait_reached;
  logic              cnt_clr_c;
  logic              cnt_inc_c;

  assign cnt_clr_c = (state_q == SETUP);
  assign cnt_inc_c = (state_q == ACCESS);

  // Strobe-active wait states before memReady is honoured.
  mem_wait_cnt #(.LIMIT(WAIT_CYCLES)) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr_c),
    .inc     (cnt_inc_c),
    .reached (wait_reached)
  );

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  logic to_reached;

  // ACCESS-cycle budget; reached during the last permitted ACCESS cycle.
  mem_wait_cnt #(.LIMIT(TO_LIMIT)) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr_c),
    .inc     (cnt_inc_c),
    .reached (to_reached)
  );
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Next state, latched request fields and next registered output values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.rdReq) begin
          op_d    = READ;
          addr_d  = bus.addrIn;
          err_d   = 1'b0;
          state_d = SETUP;
        end else if (bus.wrReq) begin
          op_d    = WRITE;
          addr_d  = bus.addrIn;
          wdata_d = bus.wrData;
          err_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (wait_reached && bus.memReady) begin
          if (op_q == READ) begin
            rdata_d = bus.memRData;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
`ifdef MEM_CTRL_TIMEOUT_EN
        else if (to_reached) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      LOAD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    load_d = (state_d == LOAD);
    re_d   = (state_d == ACCESS) && (op_d == READ);
    we_d   = (state_d == ACCESS) && (op_d == WRITE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      re_q    <= re_d;
      we_q    <= we_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.mdrData  = rdata_q;
  assign bus.mdrLoad  = load_q;
  assign bus.memAddr  = addr_q;
  assign bus.memWData = wdata_q;
  assign bus.memRe    = re_q;
  assign bus.memWe    = we_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized transactions against a cycle-timeline
// reference model of the memory access sequencer.
module tb_mem_ctrl;

  localparam int unsigned W  = 2;
  localparam int unsigned TO = 16;

  logic clk;
  logic reset;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [15:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_mdr   = '0;

  mem_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_ctrl #(
    .ADDR_W        (16),
    .DATA_W        (16),
    .WAIT_CYCLES   (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the expected values for this cycle.
  task automatic chk_all(input string pfx, input logic busy, input logic done,
                         input logic load, input logic re, input logic we,
                         input logic err);
    chk1 ({pfx, " busy"},     bus.busy,     busy);
    chk1 ({pfx, " done"},     bus.done,     done);
    chk1 ({pfx, " mdrLoad"},  bus.mdrLoad,  load);
    chk1 ({pfx, " memRe"},    bus.memRe,    re);
    chk1 ({pfx, " memWe"},    bus.memWe,    we);
    chk1 ({pfx, " err"},      bus.err,      err);
    chk16({pfx, " memAddr"},  bus.memAddr,  m_addr);
    chk16({pfx, " memWData"}, bus.memWData, m_wdata);
    chk16({pfx, " mdrData"},  bus.mdrData,  m_mdr);
  endtask

  // One transaction. Expected timeline from acceptance edge N: ACCESS holds
  // max(WAIT,low)+1 cycles starting at N+2, LOAD follows for reads, then DONE.
  // memReady is low for the first 'low' ACCESS cycles.
  task automatic run_txn(input string name, input bit rd, input bit both,
                         input logic [15:0] a, input logic [15:0] d,
                         input int unsigned low, input bit noise, input bit hold);
    int unsigned L;
    int unsigned D;
    logic [15:0] rdata;
    L = ((low > W) ? low : W) + 1;
    D = rd ? L + 3 : L + 2;
    rdata = 16'($urandom);
    bus.rdReq  = rd;
    bus.wrReq  = !rd || both;
    bus.addrIn = a;
    bus.wrData = d;
    step();
    m_addr = a;
    if (!rd) m_wdata = d;
    for (int unsigned c = 1; c <= D + 1; c++) begin
      bus.memReady = (c >= low + 2);
      bus.memRData = bus.memReady ? rdata : 16'($urandom);
      if (!hold) begin
        if (noise && c < D) begin
          bus.rdReq = 1'($urandom);
          bus.wrReq = 1'($urandom);
        end else begin
          bus.rdReq = 1'b0;
          bus.wrReq = 1'b0;
        end
      end
      if (rd && c == L + 2) m_mdr = rdata;
      chk_all($sformatf("%s c%0d", name, c),
              c <= D, c == D, rd && c == L + 2,
              rd && c >= 2 && c <= L + 1, !rd && c >= 2 && c <= L + 1, 1'b0);
      if (c <= D) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, both, noise;
    reset        = 1'b0;
    bus.rdReq    = 1'b0;
    bus.wrReq    = 1'b0;
    bus.addrIn   = '0;
    bus.wrData   = '0;
    bus.memRData = '0;
    bus.memReady = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_txn("rd_beef", 1'b1, 1'b0, 16'h0040, 16'h5555, 0, 1'b0, 1'b0);
    chk16("rd_beef value", bus.mdrData, m_mdr);
    run_txn("wr_1234", 1'b0, 1'b0, 16'h0100, 16'h1234, 0, 1'b0, 1'b0);
    run_txn("rd_slow", 1'b1, 1'b0, 16'h0200, 16'h0000, W + 4, 1'b0, 1'b0);
    run_txn("wr_slow", 1'b0, 1'b0, 16'h0300, 16'hA5A5, W + 4, 1'b0, 1'b0);
    run_txn("both",    1'b1, 1'b1, 16'h0400, 16'hDEAD, 1, 1'b0, 1'b0);
    run_txn("noise",   1'b0, 1'b0, 16'h0500, 16'h7777, 3, 1'b1, 1'b0);
    run_txn("held",    1'b1, 1'b0, 16'h0600, 16'h0000, 0, 1'b0, 1'b1);
    run_txn("next",    1'b1, 1'b0, 16'h0601, 16'h0000, 0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rd    = 1'($urandom);
      both  = rd && 1'($urandom);
      noise = 1'($urandom);
      run_txn($sformatf("rnd%0d", i), rd, both, 16'($urandom), 16'($urandom),
              $urandom_range(0, 6), noise, 1'b0);
    end

    // Reset during ACCESS aborts the read without a done pulse.
    bus.rdReq    = 1'b1;
    bus.addrIn   = 16'h0ABC;
    bus.memReady = 1'b0;
    step();
    bus.rdReq = 1'b0;
    step();
    step();
    chk1("rst_mid memRe", bus.memRe, 1'b1);
    reset = 1'b0;
    step();
    m_addr  = '0;
    m_wdata = '0;
    m_mdr   = '0;
    chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk_all("rst_rel0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("rst_rel1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("after_rst", 1'b1, 1'b0, 16'h0C0C, 16'h0000, 0, 1'b0, 1'b0);

`ifdef MEM_CTRL_TIMEOUT_EN
    // memReady stuck low: 16 ACCESS cycles, then DONE with err set.
    bus.rdReq    = 1'b1;
    bus.addrIn   = 16'h0DDD;
    bus.memReady = 1'b0;
    step();
    m_addr = 16'h0DDD;
    for (int unsigned c = 1; c <= TO + 3; c++) begin
      bus.rdReq = 1'b0;
      chk_all($sformatf("tmo c%0d", c), c <= TO + 2, c == TO + 2, 1'b0,
              c >= 2 && c <= TO + 1, 1'b0, c >= TO + 2);
      if (c <= TO + 2) step();
    end
    run_txn("tmo_clr", 1'b0, 1'b0, 16'h0EEE, 16'h4321, 0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
